axil_arbiter_2x1: RTL
=====================

# axil_arbiter_2x1

Two-master to one-slave AXI4-Lite arbiter that shares the register-space AXI4-Lite bus between the SPI-to-AXI bridge (port 0) and a second master such as a debug/DMA engine (port 1). It runs one transaction at a time with round-robin fairness and routes each response back to the master that issued the request. It sits between the bridge and the register bank of the Goertzel core.

## Interface
Parameters:
- ADDR_W, 32, address width of all address channels
- DATA_W, 32, data width; strobe width is DATA_W/8

Ports (N ∈ {0,1}; the s0_* and s1_* bundles are identical):
- axi_clk  in  1  clock; all logic is on the rising edge
- axi_rstn  in  1  reset, asynchronous, active-low
- sN_awvalid/awaddr/awprot  in  1/ADDR_W/3  ; sN_awready  out  1  write address from master N
- sN_wvalid/wdata/wstrb  in  1/DATA_W/DATA_W/8  ; sN_wready  out  1  write data from master N
- sN_bvalid/bresp  out  1/2  ; sN_bready  in  1  write response to master N
- sN_arvalid/araddr/arprot  in  1/ADDR_W/3  ; sN_arready  out  1  read address from master N
- sN_rvalid/rdata/rresp  out  1/DATA_W/2  ; sN_rready  in  1  read data to master N
- m_aw*, m_w*, m_b*, m_ar*, m_r*: the same set of signals toward the slave, with directions mirrored
- grant  out  2  one-hot owner of the bus; 2'b00 when in IDLE
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_RESP. Registers: state, gnt (1 bit), last_gnt (1 bit), aw_done, w_done.
- Request from master N: req_wN = sN_awvalid; req_rN = sN_arvalid. Inside one master, a write wins over a read.
- Arbitration in IDLE:
  - If exactly one master requests, that master is granted.
  - If both request, the master ≠ last_gnt is granted.
  - gnt is loaded, and the next state is WR_ADDR for a write or RD_ADDR for a read.
- RD_ADDR:
  - m_arvalid = s[gnt]_arvalid; m_araddr and m_arprot are muxed from s[gnt].
  - s[gnt]_arready = m_arready.
  - On the m_ar handshake → RD_DATA.
- RD_DATA:
  - s[gnt]_rvalid/rdata/rresp = m_rvalid/rdata/rresp; m_rready = s[gnt]_rready.
  - On the r handshake → IDLE, and last_gnt ← gnt.
- WR_ADDR:
  - AW and W are forwarded independently. m_awvalid = s[gnt]_awvalid & !aw_done; m_wvalid = s[gnt]_wvalid & !w_done.
  - Each handshake sets its own done flag. When both are complete (registered or current cycle) → WR_RESP and both flags clear.
  - W may complete before AW.
- WR_RESP:
  - m_b* is forwarded to and from s[gnt].
  - On the b handshake → IDLE, and last_gnt ← gnt.
- Non-granted master, and every master while in IDLE:
  - all ready and valid outputs are 0;
  - rdata, rresp and bresp are 0.
- m_* payload outputs (addr, prot, data, strb) are 0 in IDLE.
- Response codes pass through unmodified; the arbiter never generates SLVERR/DECERR.
- Reset, asynchronous at any time:
  - state ← IDLE, gnt ← 0, last_gnt ← 1, so port 0 wins the first tie;
  - aw_done and w_done ← 0;
  - every valid and ready output is 0, grant = 0, busy = 0.
  - A transaction aborted by reset is dropped; there is no recovery.

## Timing
- Arbitration latency: a request sampled in IDLE at edge k is presented on m_* in the cycle after edge k. m_*valid is combinational from s[gnt]_*valid thereafter.
- Datapath mux is combinational from the registered state/gnt, giving zero added latency per channel beat.
- Minimum read: 1 arbitration cycle, plus the AR handshake cycle, plus the R handshake cycle, plus the return to IDLE.
- Back-to-back: the next grant can be decided in the first IDLE cycle after a completed transaction. A master holding its request continuously while the other also requests alternates ownership every transaction.
- Holding valid and payload stable until the handshake is the upstream master's AXI obligation; the arbiter does not buffer.
- grant/busy are registered-state decodes and carry no combinational path from inputs.

## Test plan
- Single read, port 0: s0 araddr=0x0000_0010; slave returns rdata=0xCAFE_0001, rresp=0 one cycle after AR. Required: s0 rdata=0xCAFE_0001; s1 rvalid stays 0; grant=2'b01 during the transfer.
- Single write, port 1, W before AW: wdata=0x1234_5678, wstrb=0xF; awaddr=0x20 two cycles later. Required: slave sees exactly one AW and one W handshake; s1_bresp=0; busy drops after the B handshake.
- Simultaneous requests from both masters, held for 4 transactions. Required: grant order 0,1,0,1; no transaction lost.
- Master 0 asserts awvalid and arvalid together. Required: the write is served first, then the read, with correct responses.
- Slave returns rresp=2'b10 and bresp=2'b11. Required: the same codes reach the owning master unchanged.
- axi_rstn pulsed low during RD_DATA (slave is stalling rvalid). Required: all outputs 0 immediately; after release, a new port-1 read completes normally.

Source files
------------

// File: rtl/axil_arbiter_2x1.sv
// axil_arbiter_2x1: round-robin 2:1 AXI4-Lite arbiter, one transaction at a time.
module axil_arbiter_2x1 #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                axi_clk,
    input  logic                axi_rstn,
    input  logic                s0_awvalid,
    input  logic [ADDR_W-1:0]   s0_awaddr,
    input  logic [2:0]          s0_awprot,
    output logic                s0_awready,
    input  logic                s0_wvalid,
    input  logic [DATA_W-1:0]   s0_wdata,
    input  logic [DATA_W/8-1:0] s0_wstrb,
    output logic                s0_wready,
    output logic                s0_bvalid,
    output logic [1:0]          s0_bresp,
    input  logic                s0_bready,
    input  logic                s0_arvalid,
    input  logic [ADDR_W-1:0]   s0_araddr,
    input  logic [2:0]          s0_arprot,
    output logic                s0_arready,
    output logic                s0_rvalid,
    output logic [DATA_W-1:0]   s0_rdata,
    output logic [1:0]          s0_rresp,
    input  logic                s0_rready,
    input  logic                s1_awvalid,
    input  logic [ADDR_W-1:0]   s1_awaddr,
    input  logic [2:0]          s1_awprot,
    output logic                s1_awready,
    input  logic                s1_wvalid,
    input  logic [DATA_W-1:0]   s1_wdata,
    input  logic [DATA_W/8-1:0] s1_wstrb,
    output logic                s1_wready,
    output logic                s1_bvalid,
    output logic [1:0]          s1_bresp,
    input  logic                s1_bready,
    input  logic                s1_arvalid,
    input  logic [ADDR_W-1:0]   s1_araddr,
    input  logic [2:0]          s1_arprot,
    output logic                s1_arready,
    output logic                s1_rvalid,
    output logic [DATA_W-1:0]   s1_rdata,
    output logic [1:0]          s1_rresp,
    input  logic                s1_rready,
    output logic                m_awvalid,
    output logic [ADDR_W-1:0]   m_awaddr,
    output logic [2:0]          m_awprot,
    input  logic                m_awready,
    output logic                m_wvalid,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,
    input  logic                m_wready,
    input  logic                m_bvalid,
    input  logic [1:0]          m_bresp,
    output logic                m_bready,
    output logic                m_arvalid,
    output logic [ADDR_W-1:0]   m_araddr,
    output logic [2:0]          m_arprot,
    input  logic                m_arready,
    input  logic                m_rvalid,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic [1:0]          m_rresp,
    output logic                m_rready,
    output logic [1:0]          grant,
    output logic                busy
);
    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_RESP} state_t;
    state_t     state_q, state_d;
    logic       gnt_q, gnt_d, last_gnt_q, last_gnt_d;
    logic       aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic [1:0] grant_q, grant_d;
    logic       busy_q, busy_d;
    logic       req0, req1, pick, aw_all, w_all;
    logic       in_ra, in_rd, in_wa, in_wr;
    assign grant = grant_q;
    assign busy  = busy_q;
    always_comb begin
        in_ra = state_q == RD_ADDR;
        in_rd = state_q == RD_DATA;
        in_wa = state_q == WR_ADDR;
        in_wr = state_q == WR_RESP;
        m_awvalid  = in_wa & ~aw_done_q & (gnt_q ? s1_awvalid : s0_awvalid);
        m_awaddr   = in_wa ? (gnt_q ? s1_awaddr : s0_awaddr) : '0;
        m_awprot   = in_wa ? (gnt_q ? s1_awprot : s0_awprot) : 3'b000;
        m_wvalid   = in_wa & ~w_done_q & (gnt_q ? s1_wvalid : s0_wvalid);
        m_wdata    = in_wa ? (gnt_q ? s1_wdata : s0_wdata) : '0;
        m_wstrb    = in_wa ? (gnt_q ? s1_wstrb : s0_wstrb) : '0;
        m_bready   = in_wr & (gnt_q ? s1_bready : s0_bready);
        m_arvalid  = in_ra & (gnt_q ? s1_arvalid : s0_arvalid);
        m_araddr   = in_ra ? (gnt_q ? s1_araddr : s0_araddr) : '0;
        m_arprot   = in_ra ? (gnt_q ? s1_arprot : s0_arprot) : 3'b000;
        m_rready   = in_rd & (gnt_q ? s1_rready : s0_rready);
        s0_awready = in_wa & ~gnt_q & ~aw_done_q & m_awready;
        s0_wready  = in_wa & ~gnt_q & ~w_done_q & m_wready;
        s0_bvalid  = in_wr & ~gnt_q & m_bvalid;
        s0_bresp   = (in_wr & ~gnt_q) ? m_bresp : 2'b00;
        s0_arready = in_ra & ~gnt_q & m_arready;
        s0_rvalid  = in_rd & ~gnt_q & m_rvalid;
        s0_rdata   = (in_rd & ~gnt_q) ? m_rdata : '0;
        s0_rresp   = (in_rd & ~gnt_q) ? m_rresp : 2'b00;
        s1_awready = in_wa & gnt_q & ~aw_done_q & m_awready;
        s1_wready  = in_wa & gnt_q & ~w_done_q & m_wready;
        s1_bvalid  = in_wr & gnt_q & m_bvalid;
        s1_bresp   = (in_wr & gnt_q) ? m_bresp : 2'b00;
        s1_arready = in_ra & gnt_q & m_arready;
        s1_rvalid  = in_rd & gnt_q & m_rvalid;
        s1_rdata   = (in_rd & gnt_q) ? m_rdata : '0;
        s1_rresp   = (in_rd & gnt_q) ? m_rresp : 2'b00;
    end
    always_comb begin
        req0       = s0_awvalid | s0_arvalid;
        req1       = s1_awvalid | s1_arvalid;
        pick       = (req0 & req1) ? ~last_gnt_q : req1;
        aw_all     = aw_done_q | (m_awvalid & m_awready);
        w_all      = w_done_q | (m_wvalid & m_wready);
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_gnt_d = last_gnt_q;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;
        case (state_q)
            IDLE: if (req0 | req1) begin
                gnt_d   = pick;
                state_d = (pick ? s1_awvalid : s0_awvalid) ? WR_ADDR : RD_ADDR;
            end
            RD_ADDR: if (m_arvalid & m_arready) state_d = RD_DATA;
            RD_DATA: if (m_rvalid & m_rready) begin
                state_d    = IDLE;
                last_gnt_d = gnt_q;
            end
            WR_ADDR: begin
                state_d   = (aw_all & w_all) ? WR_RESP : WR_ADDR;
                aw_done_d = aw_all & ~w_all;
                w_done_d  = w_all & ~aw_all;
            end
            WR_RESP: if (m_bvalid & m_bready) begin
                state_d    = IDLE;
                last_gnt_d = gnt_q;
            end
            default: state_d = IDLE;
        endcase
        grant_d = (state_d == IDLE) ? 2'b00 : (gnt_d ? 2'b10 : 2'b01);
        busy_d  = state_d != IDLE;
    end
    always_ff @(posedge axi_clk or negedge axi_rstn) begin
        if (!axi_rstn) begin
            state_q    <= IDLE;
            gnt_q      <= 1'b0;
            last_gnt_q <= 1'b1;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            grant_q    <= 2'b00;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            last_gnt_q <= last_gnt_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
            grant_q    <= grant_d;
            busy_q     <= busy_d;
        end
    end
endmodule
